code_sender: RTL and testbench

Serial code transmitter that drives the single-bit entry line `x` of the alarm lock. On request it clears the lock, then shifts a parallel code out MSB-first at one bit per clock. It then watches the lock's unlock indication and reports success or failure, with a bounded wait. It sits between the keypad/controller logic and the lock and shares its clock domain.

---
 rtl/code_sender_pkg.sv | 24 ++
 rtl/code_sender_if.sv | 42 ++++
 rtl/code_sender_piso.sv | 27 ++
 rtl/code_sender.sv | 112 +++++++++++
 tb/tb_code_sender.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/code_sender_pkg.sv
// Shared definitions for the serial code sender and the alarm lock it drives:
// state encodings, default sizing and the idle (mark) level of the entry line.
package code_sender_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_OPEN = 3'd4,
    ST_FAIL = 3'd5
  } state_e;

  localparam int DEFAULT_CODE_LEN = 4;
  localparam int DEFAULT_TIMEOUT  = 8;

  // Level of the entry line whenever no code bit is being driven.
  localparam logic IDLE_LINE = 1'b1;

  function automatic logic state_is_busy(input state_e s);
    return (s == ST_CLR) || (s == ST_SEND) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/code_sender_if.sv
// Signal bundle between the keypad/controller side, the lock and code_sender.
interface code_sender_if
  import code_sender_pkg::*;
#(
  parameter int CODE_LEN = DEFAULT_CODE_LEN
) ();

  // Handshake: start is a level request with no ready; it is taken only on an
  // edge where the sender is in IDLE or FAIL. While busy is high requests are
  // dropped, not queued. code must be valid on the same edge that start is taken.
  logic                start;
  logic [CODE_LEN-1:0] code;
  logic                unlocked;
  logic                x;
  logic                lock_clr;
  logic                busy;
  logic                opened;
  logic                fail;

  modport master (
    output start,
    output code,
    output unlocked,
    input  x,
    input  lock_clr,
    input  busy,
    input  opened,
    input  fail
  );

  modport slave (
    input  start,
    input  code,
    input  unlocked,
    output x,
    output lock_clr,
    output busy,
    output opened,
    output fail
  );

endinterface

// File: rtl/code_sender_piso.sv
// Parallel-in/serial-out shift register: load wins over shift, MSB leaves first.
module code_piso #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sreg_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg_q <= '0;
    end else if (load) begin
      sreg_q <= din;
    end else if (shift_en) begin
      sreg_q <= sreg_q << 1;
    end
  end

  assign msb = sreg_q[WIDTH-1];

endmodule

// File: rtl/code_sender.sv
// Serial code transmitter: clears the lock, shifts the code out MSB-first on x,
// then waits a bounded time for the lock's unlocked indication.
module code_sender
  import code_sender_pkg::*;
#(
  parameter int CODE_LEN = DEFAULT_CODE_LEN,
  parameter int TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset_n,
  code_sender_if.slave bus,
  output state_e       state_dbg
);

  localparam logic [3:0] LAST_BIT  = 4'(CODE_LEN - 1);
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] bit_cnt_q;
  logic [7:0] wait_cnt_q;
  logic       load;
  logic       shift_en;
  logic       piso_msb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE, ST_FAIL: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = ST_CLR;
        end
      end
      ST_CLR: begin
        state_d = ST_SEND;
      end
      ST_SEND: begin
        shift_en = 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.unlocked) begin
          state_d = ST_OPEN;
        end else if (wait_cnt_q == LAST_WAIT) begin
          state_d = ST_FAIL;
        end
      end
      ST_OPEN: begin
        if (!bus.unlocked) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bit counter is zeroed on capture and again in CLR, so SEND always starts at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q <= '0;
    end else if (load || (state_q == ST_CLR)) begin
      bit_cnt_q <= '0;
    end else if (state_q == ST_SEND) begin
      bit_cnt_q <= bit_cnt_q + 4'd1;
    end
  end

  // Wait counter only runs inside WAIT; any other state holds it at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
    end else if (state_q != ST_WAIT) begin
      wait_cnt_q <= '0;
    end else if (!bus.unlocked) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end

  code_piso #(
    .WIDTH (CODE_LEN)
  ) u_piso (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .shift_en (shift_en),
    .din      (bus.code),
    .msb      (piso_msb)
  );

  assign bus.x        = (state_q == ST_SEND) ? piso_msb : IDLE_LINE;
  assign bus.lock_clr = (state_q == ST_CLR);
  assign bus.busy     = state_is_busy(state_q);
  assign bus.opened   = (state_q == ST_OPEN);
  assign bus.fail     = (state_q == ST_FAIL);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_code_sender.sv
// Self-checking bench for code_sender: a 4-bit/8-cycle instance for the main
// scenarios and a 1-bit/1-cycle instance for the boundary parameters.
module tb_code_sender;
  import code_sender_pkg::*;

  localparam int W = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  code_sender_if #(.CODE_LEN(4)) bus_a ();
  code_sender_if #(.CODE_LEN(1)) bus_b ();
  state_e state_a;
  state_e state_b;

  code_sender #(.CODE_LEN(4), .TIMEOUT(8)) dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus_a),
    .state_dbg (state_a)
  );

  code_sender #(.CODE_LEN(1), .TIMEOUT(1)) dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus_b),
    .state_dbg (state_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output vectors packed as {x, lock_clr, busy, opened, fail}.
  function automatic logic [4:0] outs_a();
    return {bus_a.x, bus_a.lock_clr, bus_a.busy, bus_a.opened, bus_a.fail};
  endfunction

  function automatic logic [4:0] outs_b();
    return {bus_b.x, bus_b.lock_clr, bus_b.busy, bus_b.opened, bus_b.fail};
  endfunction

  // ---------------- driver tasks (entered just after a negedge) ----------------
  task automatic run_send_a(input logic [3:0] c, input bit disturb, input string tag);
    logic [W-1:0] e;
    bus_a.start = 1'b1;
    bus_a.code  = c;
    for (int i = 3; i >= 0; i--) exp_q.push_back(c[i]);
    @(negedge clk);
    bus_a.start = 1'b0;
    check($sformatf("%s_clr", tag), 32'(outs_a()), 32'(5'b11100));
    for (int i = 0; i < 4; i++) begin
      if (disturb && i == 1) begin
        bus_a.start = 1'b1;
        bus_a.code  = ~c;
      end
      if (disturb && i == 2) bus_a.start = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("%s_bit%0d", tag, i), 32'(outs_a()), 32'({e[0], 4'b0100}));
    end
  endtask

  task automatic open_lock_a(input int hold, input string tag);
    @(negedge clk);
    check($sformatf("%s_wait", tag), 32'(outs_a()), 32'(5'b10100));
    bus_a.unlocked = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("%s_open%0d", tag, i), 32'(outs_a()), 32'(5'b10010));
    end
    bus_a.unlocked = 1'b0;
    @(negedge clk);
    check($sformatf("%s_idle", tag), 32'(outs_a()), 32'(5'b10000));
    check($sformatf("%s_state", tag), 32'(state_a), 32'(ST_IDLE));
  endtask

  task automatic timeout_a(input string tag);
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      check($sformatf("%s_wait%0d", tag, w), 32'(outs_a()), 32'(5'b10100));
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("%s_fail%0d", tag, i), 32'(outs_a()), 32'(5'b10001));
    end
  endtask

  task automatic run_b(input logic c, input string tag);
    logic [W-1:0] e;
    bus_b.start = 1'b1;
    bus_b.code  = c;
    exp_q.push_back(c);
    @(negedge clk);
    bus_b.start = 1'b0;
    check($sformatf("%s_clr", tag), 32'(outs_b()), 32'(5'b11100));
    @(negedge clk);
    e = exp_q.pop_front();
    check($sformatf("%s_bit", tag), 32'(outs_b()), 32'({e[0], 4'b0100}));
    @(negedge clk);
    check($sformatf("%s_wait", tag), 32'(outs_b()), 32'(5'b10100));
    @(negedge clk);
    check($sformatf("%s_fail", tag), 32'(outs_b()), 32'(5'b10001));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] e;
    reset_n        = 1'b0;
    bus_a.start    = 1'b0;
    bus_a.code     = '0;
    bus_a.unlocked = 1'b0;
    bus_b.start    = 1'b0;
    bus_b.code     = '0;
    bus_b.unlocked = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outs_a", 32'(outs_a()), 32'(5'b10000));
    check("rst_outs_b", 32'(outs_b()), 32'(5'b10000));
    check("rst_state_a", 32'(state_a), 32'(ST_IDLE));
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_after_rst", 32'(outs_a()), 32'(5'b10000));

    // Normal open with the all-zero code.
    run_send_a(4'b0000, 1'b0, "open");
    open_lock_a(3, "open");

    // Wrong code: lock stays shut, sender times out; start is taken right after OPEN.
    run_send_a(4'b0100, 1'b0, "wrong");
    timeout_a("wrong");

    // Retry from FAIL.
    run_send_a(4'b0000, 1'b0, "retry");
    open_lock_a(2, "retry");

    // start and code toggled mid-SEND must not disturb the captured bits.
    run_send_a(4'b1011, 1'b1, "stable");
    open_lock_a(1, "stable");
    repeat (3) begin
      @(negedge clk);
      check("stable_no_reclr", 32'(outs_a()), 32'(5'b10000));
    end

    // Reset asserted during the third SEND bit.
    bus_a.start = 1'b1;
    bus_a.code  = 4'b1101;
    for (int i = 3; i >= 0; i--) exp_q.push_back(bus_a.code[i]);
    @(negedge clk);
    bus_a.start = 1'b0;
    check("rst_mid_clr", 32'(outs_a()), 32'(5'b11100));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("rst_mid_bit%0d", i), 32'(outs_a()), 32'({e[0], 4'b0100}));
    end
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_async", 32'(outs_a()), 32'(5'b10000));
    check("rst_mid_state", 32'(state_a), 32'(ST_IDLE));
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("rst_quiet%0d", i), 32'(outs_a()), 32'(5'b10000));
    end

    // Boundary: one-bit code, one-cycle timeout, then retry out of FAIL.
    run_b(1'b1, "b1");
    run_b(1'b0, "b0");

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
